// File: rtl/silent_pkg.sv
// Shared constants and types for the silent_stepper smoothing block.
package silent_pkg;

  localparam int unsigned DEFAULT_WIDTH = 13;
  localparam int unsigned DEFAULT_DEPTH = 249;

  typedef logic [DEFAULT_WIDTH-1:0] val_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/silent_step_calc.sv
// Per-channel step limiter: moves duty/phase toward clamped targets by at most one step.
module silent_step_calc
  import silent_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] duty_cur,
  input  logic [WIDTH-1:0] phase_cur,
  input  logic [WIDTH-1:0] duty_tgt,
  input  logic [WIDTH-1:0] phase_tgt,
  input  logic [WIDTH-1:0] step_duty,
  input  logic [WIDTH-1:0] step_phase,
  input  logic             enable,
  output logic [WIDTH-1:0] duty_nxt,
  output logic [WIDTH-1:0] phase_nxt
);

  // Headroom so the doubled phase delta and the wrap correction never overflow
  localparam int unsigned PW = WIDTH + 3;

  logic [WIDTH-1:0]        dt;
  logic [WIDTH-1:0]        pt;
  logic [WIDTH-1:0]        cm1;
  logic signed [WIDTH:0]   dd;
  logic signed [WIDTH:0]   sd;
  logic signed [PW-1:0]    cc;
  logic signed [PW-1:0]    sp;
  logic signed [PW-1:0]    d;
  logic signed [PW-1:0]    nw;

  // Clamp targets into the channel's cycle, then step-limit duty and shortest-path phase
  always_comb begin
    cm1       = c - WIDTH'(1);
    dt        = (duty_tgt > c) ? c : duty_tgt;
    pt        = (phase_tgt > cm1) ? cm1 : phase_tgt;
    dd        = $signed({1'b0, dt}) - $signed({1'b0, duty_cur});
    sd        = $signed({1'b0, step_duty});
    cc        = $signed({3'b000, c});
    sp        = $signed({3'b000, step_phase});
    d         = $signed({3'b000, pt}) - $signed({3'b000, phase_cur});
    nw        = '0;
    duty_nxt  = dt;
    phase_nxt = pt;

    if (c == '0) begin
      duty_nxt  = '0;
      phase_nxt = '0;
    end else if (enable) begin
      if (dd > sd)       duty_nxt = duty_cur + step_duty;
      else if (dd < -sd) duty_nxt = duty_cur - step_duty;
      else               duty_nxt = dt;

      // Fold delta onto the shorter arc; an exact half cycle stays positive
      if ((d <<< 1) > cc)        d = d - cc;
      else if ((d <<< 1) <= -cc) d = d + cc;

      if (d > sp)       d = sp;
      else if (d < -sp) d = -sp;

      nw = $signed({3'b000, phase_cur}) + d;
      if (nw < 0)        nw = nw + cc;
      else if (nw >= cc) nw = nw - cc;
      phase_nxt = WIDTH'(nw);
    end
  end

endmodule

// File: rtl/silent_stepper.sv
// Sweeps all channels one per clock on UPDATE, stepping smoothed duty/phase toward targets.
module silent_stepper
  import silent_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic             UPDATE,
  input  logic [WIDTH-1:0] STEP_DUTY,
  input  logic [WIDTH-1:0] STEP_PHASE,
  input  logic [WIDTH-1:0] CYCLE   [DEPTH],
  input  logic [WIDTH-1:0] DUTY    [DEPTH],
  input  logic [WIDTH-1:0] PHASE   [DEPTH],
  output logic [WIDTH-1:0] DUTY_S  [DEPTH],
  output logic [WIDTH-1:0] PHASE_S [DEPTH],
  output logic             BUSY,
  output logic             OUT_VALID,
  output logic             OVERRUN
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] duty_nxt;
  logic [WIDTH-1:0] phase_nxt;

  // Shared limiter fed by the channel currently selected by idx
  silent_step_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .c         (CYCLE[idx]),
    .duty_cur  (DUTY_S[idx]),
    .phase_cur (PHASE_S[idx]),
    .duty_tgt  (DUTY[idx]),
    .phase_tgt (PHASE[idx]),
    .step_duty (STEP_DUTY),
    .step_phase(STEP_PHASE),
    .enable    (ENABLE),
    .duty_nxt  (duty_nxt),
    .phase_nxt (phase_nxt)
  );

  // Sweep control: IDLE -> RUN over DEPTH channels -> DONE (one-cycle OUT_VALID) -> IDLE
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      idx       <= '0;
      BUSY      <= 1'b0;
      OUT_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      if (UPDATE && (state != IDLE)) OVERRUN <= 1'b1;
      case (state)
        IDLE: begin
          if (UPDATE) begin
            state <= RUN;
            idx   <= '0;
            BUSY  <= 1'b1;
          end
        end
        RUN: begin
          if (idx == IW'(DEPTH - 1)) begin
            state     <= DONE;
            idx       <= '0;
            BUSY      <= 1'b0;
            OUT_VALID <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Smoothed output arrays; only the channel under the index changes each RUN cycle
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        DUTY_S[i]  <= '0;
        PHASE_S[i] <= '0;
      end
    end else if (state == RUN) begin
      DUTY_S[idx]  <= duty_nxt;
      PHASE_S[idx] <= phase_nxt;
    end
  end

endmodule

// File: doc/silent_stepper.md
Name: silent_stepper

Overview:
- Parametrised successor to the fixed-depth silencer. On each UPDATE pulse it walks all DEPTH transducer channels, one per clock.
- For each channel it moves the smoothed duty and phase toward their targets by at most a configurable step.
- Phase takes the shortest path modulo the channel's own cycle and wraps.
- Sits between the target registers and the transducers block, in the CLK_L domain.

Parameters:
- WIDTH, 13, bit width of cycle/duty/phase/step values.
- DEPTH, 249, number of transducer channels.

Ports:
- CLK  input  1  processing clock.
- RESET_N  input  1  asynchronous, active-low reset.
- ENABLE  input  1  1 = step-limited smoothing; 0 = bypass (targets copied in one sweep).
- UPDATE  input  1  single-cycle sweep request.
- STEP_DUTY  input  WIDTH  max duty change per sweep.
- STEP_PHASE  input  WIDTH  max phase change per sweep.
- CYCLE  input  DEPTH x WIDTH  per-channel period.
- DUTY  input  DEPTH x WIDTH  target duty.
- PHASE  input  DEPTH x WIDTH  target phase.
- DUTY_S  output  DEPTH x WIDTH  smoothed duty.
- PHASE_S  output  DEPTH x WIDTH  smoothed phase.
- BUSY  output  1  sweep in progress.
- OUT_VALID  output  1  one-cycle pulse when a sweep completes.
- OVERRUN  output  1  sticky: UPDATE arrived while BUSY.

Behaviour:
- Reset (async assert, sync release): DUTY_S and PHASE_S all 0, BUSY=0, OUT_VALID=0, OVERRUN=0, FSM=IDLE, index=0.
- FSM states:
  - IDLE: UPDATE=1 -> RUN, index=0, BUSY=1 from next cycle.
  - RUN: one channel per cycle. Channel i is written at edge k+1+i, where k is the edge UPDATE was sampled.
  - RUN exit: after index DEPTH-1 -> DONE.
  - DONE: OUT_VALID=1 for exactly one cycle, BUSY=0, then IDLE.
  - Total latency: OUT_VALID high DEPTH+1 cycles after UPDATE is sampled.
- UPDATE while RUN or DONE: ignored; OVERRUN set to 1 until reset. An UPDATE in the same cycle as OUT_VALID is also ignored.
- Inputs are sampled per channel at processing time. Targets changed mid-sweep are therefore seen by later channels only.
- Target clamp, for c = CYCLE[i]:
  - c = 0: DUTY_S[i] = PHASE_S[i] = 0.
  - Otherwise dt = min(DUTY[i], c) and pt = min(PHASE[i], c-1).
- Duty, ENABLE=1:
  - If |dt - DUTY_S| <= STEP_DUTY, new = dt.
  - Otherwise new = DUTY_S ± STEP_DUTY toward dt.
  - Use WIDTH+1-bit signed arithmetic; no overflow.
- Phase, ENABLE=1:
  - d = pt - PHASE_S, signed WIDTH+2 bits.
  - If 2d > c: d -= c. If 2d <= -c: d += c. An exact half-cycle tie therefore moves in the positive direction.
  - Clamp d to ±STEP_PHASE.
  - new = PHASE_S + d. If new < 0: new += c. If new >= c: new -= c.
- ENABLE=0: new duty = dt, new phase = pt.
- STEP = 0 with ENABLE=1: outputs hold their values.
- Channels not yet reached in a sweep hold their values.

Decomposition:
- Package silent_pkg holds:
  - default WIDTH/DEPTH constants;
  - typedef val_t = logic [WIDTH-1:0];
  - FSM enum {IDLE, RUN, DONE}.
- Sub-module silent_step_calc: purely combinational, one instance. Inputs c, current duty/phase, target duty/phase, both steps and ENABLE; outputs next duty/phase.
- The top module holds the FSM, the index counter, the mux reading the indexed channel, and the output register arrays.

Test Plan:
- Duty ramp: all CYCLE=5000, DUTY 0->2500, STEP_DUTY=100, ENABLE=1 -> DUTY_S=100 after sweep 1 and 2500 after sweep 25, unchanged at sweep 26. OUT_VALID exactly DEPTH+1 cycles after each UPDATE.
- Phase wrap: c=5000, PHASE_S=4950, target 50, STEP_PHASE=40 -> 4990, 30, 50 on successive sweeps.
- Half-cycle tie and clamp: c=5000, PHASE_S=0, target 2500, step 100 -> 100. Separately, target 6000 -> clamped to 4999, reached via the backward path (-1 per step ≤ 100 => 4999 in one sweep).
- Bypass: ENABLE=0, targets duty 1234 / phase 4321, c=5000 -> all channels equal targets after one sweep. c=0 channel -> 0/0.
- Overrun: second UPDATE 10 cycles after the first -> only one OUT_VALID pulse, OVERRUN=1, BUSY low after DEPTH+1 cycles.
- Reset mid-sweep: assert RESET_N=0 at index 100 -> outputs immediately 0, BUSY=0, OVERRUN=0. A fresh UPDATE after release completes normally.
